// File: rtl/cell_reader_pkg.sv
// Shared types and constants for the cell position reader: FSM state encoding,
// memory layout constants and the {index, data} entry held in the output FIFO.
package cell_reader_pkg;

  localparam int CELL_DATA_WIDTH = 96;
  localparam int CELL_ADDR_WIDTH = 8;

  // Address 0 of a cell memory holds the particle count, particles follow at 1..count.
  localparam int COUNT_ADDR     = 0;
  localparam int MEM_RD_LATENCY = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CNT,
    ST_WAIT_CNT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [CELL_ADDR_WIDTH-1:0] index;
    logic [CELL_DATA_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/cell_reader_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented on o_rdata the cycle
// after it is written; i_rd pops it. Writes while full are dropped.
module cell_reader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_rd,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & ~o_empty;

  // NOTE: sequential state uses <= so every register samples pre-edge values,
  // independent of the order in which always_ff blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; r_count alone decides which entries are live,
  // which keeps the array mappable onto plain RAM/register cells without reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];

endmodule

// File: rtl/cell_pos_reader.sv
// Read-side initiator for one cell memory: fetches the particle count at address 0,
// then streams addresses 1..count through a credit-controlled show-ahead FIFO.
module cell_pos_reader
  import cell_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = CELL_DATA_WIDTH,
  parameter int ADDR_WIDTH   = CELL_ADDR_WIDTH,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_cnt,
  output logic                  cnt_overflow
);

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam int FCW       = $clog2(FIFO_DEPTH + 1);
  localparam int SW        = $clog2(FIFO_DEPTH + MEM_RD_LATENCY + 2) + 1;
  localparam int WW        = $clog2(MEM_RD_LATENCY) + 1;
  localparam int WAIT_LAST = MEM_RD_LATENCY - 1;

  state_e                r_state;
  logic [WW-1:0]         r_wait;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic                  r_mem_rden;
  logic                  r_part_rd;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;

  logic [MEM_RD_LATENCY-1:0] r_vld_sr;
  logic [ADDR_WIDTH-1:0]     r_idx_sr [MEM_RD_LATENCY];

  fifo_entry_t           w_wr_entry;
  fifo_entry_t           w_rd_entry;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [FCW-1:0]        w_fifo_count;
  logic [ADDR_WIDTH-1:0] w_raw_cnt;
  logic                  w_raw_ovf;
  logic [ADDR_WIDTH-1:0] w_clamped;
  logic [SW-1:0]         w_credit_used;
  logic                  w_can_issue;
  logic                  w_drained;

  assign w_raw_cnt = mem_q[ADDR_WIDTH-1:0];
  assign w_raw_ovf = (w_raw_cnt > MAX_CNT);
  assign w_clamped = w_raw_ovf ? MAX_CNT : w_raw_cnt;

  // Slots the next cycle will hold: reads in flight plus FIFO entries after this edge's pop.
  // A read is issued only if that leaves room for it, so the FIFO can never overflow.
  assign w_credit_used = SW'(r_part_rd) + SW'($countones(r_vld_sr)) + SW'(w_fifo_count) - SW'(w_pop);
  assign w_can_issue   = (w_credit_used < SW'(FIFO_DEPTH));

  // Drained once nothing is in flight and the final entry leaves the FIFO at this edge.
  assign w_drained = !r_part_rd && (r_vld_sr == '0) &&
                     (w_fifo_empty || (w_fifo_count == FCW'(1) && w_pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wait        <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_mem_address <= '0;
      r_mem_rden    <= 1'b0;
      r_part_rd     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_mem_rden <= 1'b0;
      r_part_rd  <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state       <= ST_RD_CNT;
            r_ovf         <= 1'b0;
            r_busy        <= 1'b1;
            r_mem_rden    <= 1'b1;
            r_mem_address <= ADDR_WIDTH'(COUNT_ADDR);
          end
        end
        ST_RD_CNT: begin
          r_state <= ST_WAIT_CNT;
          r_wait  <= '0;
        end
        ST_WAIT_CNT: begin
          if (r_wait == WW'(WAIT_LAST)) begin
            r_cnt <= w_clamped;
            r_ovf <= w_raw_ovf;
            if (w_clamped == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_mem_rden    <= 1'b1;
              r_part_rd     <= 1'b1;
              r_mem_address <= ADDR_WIDTH'(1);
              r_ptr         <= ADDR_WIDTH'(2);
              r_state       <= (w_clamped == ADDR_WIDTH'(1)) ? ST_DRAIN : ST_STREAM;
            end
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        ST_STREAM: begin
          if (w_can_issue) begin
            r_mem_rden    <= 1'b1;
            r_part_rd     <= 1'b1;
            r_mem_address <= r_ptr;
            r_ptr         <= r_ptr + ADDR_WIDTH'(1);
            if (r_ptr == r_cnt) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Valid bits follow each particle read until its data appears on mem_q.
  always_ff @(posedge clk) begin
    if (rst) r_vld_sr <= '0;
    else     r_vld_sr <= {r_vld_sr[MEM_RD_LATENCY-2:0], r_part_rd};
  end

  always_ff @(posedge clk) begin
    r_idx_sr[0] <= r_mem_address;
    for (int i = 1; i < MEM_RD_LATENCY; i++) r_idx_sr[i] <= r_idx_sr[i-1];
  end

  assign w_push           = r_vld_sr[MEM_RD_LATENCY-1];
  assign w_wr_entry.index = r_idx_sr[MEM_RD_LATENCY-1];
  assign w_wr_entry.data  = mem_q;
  assign w_pop            = out_valid & out_ready;

  cell_reader_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_push),
    .i_wdata (w_wr_entry),
    .i_rd    (w_pop),
    .o_rdata (w_rd_entry),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  a_no_fifo_overflow : assert property (@(posedge clk) disable iff (rst) !(w_push && w_fifo_full));

  assign mem_address  = r_mem_address;
  assign mem_rden     = r_mem_rden;
  assign mem_wren     = 1'b0;
  assign mem_data     = '0;
  assign busy         = r_busy;
  assign done         = r_done;
  assign particle_cnt = r_cnt;
  assign cnt_overflow = r_ovf;

  // Payload is forced to zero when no entry is presented, so idle outputs are clean.
  assign out_valid = ~w_fifo_empty;
  assign out_data  = out_valid ? w_rd_entry.data  : '0;
  assign out_index = out_valid ? w_rd_entry.index : '0;
  assign out_last  = out_valid && (w_rd_entry.index == r_cnt);

endmodule

// File: doc/cell_pos_reader.md
Name: cell_pos_reader

Overview:
- Read-side initiator for one single-port position cell memory (DATA_WIDTH {posz, posy, posx}; address 0 holds the cell particle count).
- On start, it reads the count, then issues reads to addresses 1..count and streams each particle out on a valid/ready interface, together with its in-cell index.
- Sits between a cell memory and the position cache / force pipeline front end.
- Hides the 2-cycle memory read latency behind a 4-entry credit-controlled FIFO.

Parameters:
- DATA_WIDTH, 96, width of one position word and of mem_q.
- ADDR_WIDTH, 8, memory address width.
- PARTICLE_NUM, 220, memory depth; the largest legal count is PARTICLE_NUM-1.
- FIFO_DEPTH, 4, output buffer depth; must be at least 4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to stream the cell; ignored while busy=1.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_rden  out  1  memory read enable.
- mem_wren  out  1  tied 0.
- mem_data  out  DATA_WIDTH  tied 0.
- mem_q  in  DATA_WIDTH  memory read data; valid 2 cycles after the mem_rden cycle.
- out_valid  out  1  out_data / out_index / out_last are valid.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid & out_ready.
- out_data  out  DATA_WIDTH  particle position.
- out_index  out  ADDR_WIDTH  particle address, 1..count.
- out_last  out  1  marks the final particle of the cell.
- busy  out  1  high from the cycle after start until the done cycle, inclusive.
- done  out  1  one-cycle pulse at the end of the cell.
- particle_cnt  out  ADDR_WIDTH  latched count (after clamping).
- cnt_overflow  out  1  sticky; the raw count exceeded PARTICLE_NUM-1; cleared by the next accepted start.

Behaviour:
- Reset: the state machine goes to IDLE. All outputs are 0: mem_address, mem_rden, out_valid, out_last, busy, done, particle_cnt, cnt_overflow.
- Reset also clears the FIFO, the read-issue pointer, the credit counter and the in-flight valid shift register. Data still in flight from the memory is discarded.
- Memory outputs (mem_address, mem_rden) are registered.
- FSM states: IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 at edge E0 moves to RD_CNT and clears cnt_overflow.
  - busy=1 from cycle 1.
- RD_CNT (cycle 1): mem_rden=1, mem_address=0. Then go to WAIT_CNT.
- WAIT_CNT (cycles 2-3):
  - On cycle 3, raw = mem_q[ADDR_WIDTH-1:0].
  - If raw > PARTICLE_NUM-1, latch PARTICLE_NUM-1 and set cnt_overflow; otherwise latch raw.
  - If the latched count is 0, go to DONE; otherwise go to STREAM with the issue pointer at 1.
- STREAM: issue a read (mem_rden=1, mem_address=pointer, then pointer+1) in any cycle where inflight + fifo_count < FIFO_DEPTH.
  - The first read is in cycle 4.
  - After the read of address count is issued, go to DRAIN.
- In-flight tracking: a 2-stage valid shift register tracks outstanding reads. When stage 2 is valid, mem_q and its index are written to the FIFO.
- FIFO:
  - Show-ahead; an entry is visible on out_* the cycle after it is written.
  - The first out_valid is in cycle 7.
  - Simultaneous write and read in the same cycle is legal, and the count is unchanged.
  - The FIFO never overflows because of the credit rule. A write to a full FIFO is an assertion failure.
- out_last = (out_index == particle_cnt). out_data and out_index must be held stable while out_valid & !out_ready.
- Throughput: with out_ready held at 1, one particle per cycle, no bubbles after the first.
- DRAIN: wait until inflight = 0 and the FIFO is empty, meaning the out_last handshake has completed. Then go to DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE. start is accepted again in the cycle after DONE.
- mem_rden is 0 in every state except RD_CNT and the cycles in STREAM where a read is issued.
- start while busy: ignored, with no effect on state or flags.
- rst asserted mid-stream: the next cycle is IDLE with all outputs 0, and no stale out_valid appears afterwards.

Decomposition:
- Shared package cell_reader_pkg holds:
  - the FSM state enum (3-bit);
  - the constant COUNT_ADDR = 0;
  - the constant MEM_RD_LATENCY = 2;
  - a typedef for the {index, data} FIFO entry.
- One sub-module: cell_reader_fifo, a synchronous show-ahead FIFO parameterised by width and depth, with count output and full/empty flags.

Test Plan:
- Count 3, positions P1..P3, out_ready=1:
  - start in cycle 0;
  - mem_rden at address 0 in cycle 1;
  - addresses 1, 2, 3 in cycles 4-6;
  - out_valid in cycles 7-9 with index 1, 2, 3 and out_last only in cycle 9;
  - done in cycle 10, busy low in cycle 11.
- Count 0: no particle reads and no out_valid; done in cycle 4.
- Count 5 with out_ready toggling 1,0,0,1,...:
  - all 5 words are delivered in order and are stable while stalled;
  - inflight + fifo_count never exceeds 4;
  - mem_rden pauses when credits run out.
- Raw count 250 with PARTICLE_NUM=220:
  - particle_cnt = 219 and cnt_overflow = 1;
  - the last index is 219;
  - a new start clears cnt_overflow.
- Reset in cycle 6 of a count-10 stream: from cycle 7 all outputs are 0 and no out_valid appears; a subsequent start streams correctly from index 1.
- start pulsed again during STREAM: ignored; exactly count transfers and a single done pulse.
